// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the programmable-threshold FIFO.
package fifo_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 16;

    // Read-mode encodings for the FWFT parameter
    localparam int unsigned FwftOff = 0;
    localparam int unsigned FwftOn  = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: register array with one synchronous write and one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_mem_prog.sv
// Synchronous FIFO with programmable almost-full/empty levels, sticky error flags
// and selectable registered or first-word-fall-through read.
module fifo_mem_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned FWFT   = FwftOff,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    input  logic [AW:0]       af_level,
    input  logic [AW:0]       ae_level,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic [AW:0]       fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam logic [AW:0]   CntMax = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CntOne = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    assign fifo_count        = count_q;
    assign fifo_empty        = (count_q == '0);
    assign fifo_full         = (count_q == CntMax);
    assign fifo_almost_full  = (count_q >= af_level);
    assign fifo_almost_empty = (count_q <= ae_level);
    assign fifo_overflow     = overflow_q;
    assign fifo_underflow    = underflow_q;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it
    assign rd_acc = rd & ~fifo_empty;
    assign wr_acc = wr & (~fifo_full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // Clear first so a fresh error in the same cycle keeps the flag set
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr && !wr_acc) overflow_d  = 1'b1;
        if (rd && fifo_empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    if (FWFT == FwftOn) begin : g_fwft
        assign data_out = ram_rdata;
    end else begin : g_reg
        logic [DATA_W-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= ram_rdata;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_mem_prog.sv
// Directed bench: one registered-read and one FWFT instance driven by identical stimulus.
module tb_fifo_mem_prog;

    logic       clk = 1'b0;
    logic       rst, wr, rd, clr_err;
    logic [7:0] data_in;
    logic [4:0] af_level, ae_level;

    logic [7:0] dout0, dout1;
    logic [4:0] cnt0, cnt1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_mem_prog #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut0 (
        .clk (clk), .rst (rst), .wr (wr), .rd (rd), .data_in (data_in),
        .af_level (af_level), .ae_level (ae_level), .clr_err (clr_err),
        .data_out (dout0), .fifo_count (cnt0), .fifo_full (full0), .fifo_empty (empty0),
        .fifo_almost_full (af0), .fifo_almost_empty (ae0),
        .fifo_overflow (ovf0), .fifo_underflow (unf0)
    );

    fifo_mem_prog #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut1 (
        .clk (clk), .rst (rst), .wr (wr), .rd (rd), .data_in (data_in),
        .af_level (af_level), .ae_level (ae_level), .clr_err (clr_err),
        .data_out (dout1), .fifo_count (cnt1), .fifo_full (full1), .fifo_empty (empty1),
        .fifo_almost_full (af1), .fifo_almost_empty (ae1),
        .fifo_overflow (ovf1), .fifo_underflow (unf1)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic [4:0] cnt;
        logic       empty;
        logic       ae;
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [7:0] d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] din);
        wr = w; rd = r; data_in = din;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h01, 8'h00, 5'd1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 8'h02, 8'h00, 5'd2, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'h03, 8'h00, 5'd3, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 8'h04, 8'h00, 5'd4, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h05, 8'h00, 5'd5, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h01, 5'd4, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h02, 5'd3, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 8'h03, 5'd2, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 8'h00, 8'h04, 5'd1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 8'h00, 8'h05, 5'd0, 1'b1, 1'b1};

        clr_err  = 1'b0;
        af_level = 5'd12;
        ae_level = 5'd3;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        tick();
        do_reset();

        // Reset state
        chk("rst_count", cnt0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_unf", unf0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_empty_fwft", empty1, 1);

        // Basic write-then-read, registered read
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].din);
            tick();
            chk($sformatf("tbl%0d_dout", i), dout0, tbl[i].dout);
            chk($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].cnt);
            chk($sformatf("tbl%0d_empty", i), empty0, tbl[i].empty);
            chk($sformatf("tbl%0d_ae", i), ae0, tbl[i].ae);
        end
        drive(1'b0, 1'b0, 8'h00);

        // Fill, then one write too many
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + i));
            tick();
        end
        chk("fill_full", full0, 1);
        chk("fill_count", cnt0, 16);
        chk("fill_ovf_clean", ovf0, 0);
        drive(1'b1, 1'b0, 8'hFF);
        tick();
        chk("ovf_full", full0, 1);
        chk("ovf_count", cnt0, 16);
        chk("ovf_set", ovf0, 1);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        chk("ovf_sticky", ovf0, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr", ovf0, 0);

        // Simultaneous read/write while full
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pair%0d_fwft_head", i), dout1, 8'h10 + i);
            drive(1'b1, 1'b1, 8'(8'h20 + i));
            tick();
            chk($sformatf("pair%0d_dout", i), dout0, 8'h10 + i);
            chk($sformatf("pair%0d_count", i), cnt0, 16);
            chk($sformatf("pair%0d_ovf", i), ovf0, 0);
        end

        // Drain: remaining originals then the words written during the pairs
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 12) ? 8'(8'h14 + i) : 8'(8'h20 + i - 12);
            chk($sformatf("drain%0d_fwft", i), dout1, exp_d);
            drive(1'b0, 1'b1, 8'h00);
            tick();
            chk($sformatf("drain%0d_dout", i), dout0, exp_d);
        end
        chk("drain_empty", empty0, 1);

        // Underflow, hold of data_out, clear, and error-wins-over-clear
        drive(1'b0, 1'b1, 8'h00);
        tick();
        chk("unf_set", unf0, 1);
        chk("unf_dout_hold", dout0, 8'h23);
        chk("unf_count", cnt0, 0);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        chk("unf_sticky", unf0, 1);
        clr_err = 1'b1;
        tick();
        chk("unf_clr", unf0, 0);
        drive(1'b0, 1'b1, 8'h00);
        tick();
        chk("unf_err_wins", unf0, 1);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        clr_err = 1'b0;
        chk("unf_clr2", unf0, 0);

        // Almost-full / almost-empty thresholds
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b0, 8'(8'h40 + i));
            tick();
        end
        chk("c11_af", af0, 0);
        chk("c11_ae", ae0, 0);
        drive(1'b1, 1'b0, 8'h4B);
        tick();
        chk("c12_af", af0, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
        end
        chk("c4_count", cnt0, 4);
        chk("c4_af", af0, 0);
        chk("c4_ae", ae0, 0);
        drive(1'b0, 1'b1, 8'h00);
        tick();
        chk("c3_ae", ae0, 1);

        // af_level beyond DEPTH never asserts
        af_level = 5'd17;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 1'b0, 8'(8'h60 + i));
            tick();
        end
        chk("af17_full", full0, 1);
        chk("af17_af", af0, 0);
        af_level = 5'd16;
        #1;
        chk("af16_af", af0, 1);
        af_level = 5'd12;

        // ae_level of zero tracks empty
        do_reset();
        ae_level = 5'd0;
        #1;
        chk("ae0_empty", ae0, 1);
        drive(1'b1, 1'b0, 8'h77);
        tick();
        chk("ae0_one", ae0, 0);
        ae_level = 5'd3;

        // FWFT head presentation and wrap-around with model queue
        do_reset();
        drive(1'b1, 1'b0, 8'hA5);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        chk("fwft_a5", dout1, 8'hA5);
        chk("fwft_reg_idle", dout0, 8'h00);
        tick();
        chk("fwft_a5_hold", dout1, 8'hA5);
        q.push_back(8'hA5);
        for (int i = 0; i < 40; i++) begin
            d = 8'((i * 7 + 3) & 8'hFF);
            chk($sformatf("wrap%0d_fwft", i), dout1, q[0]);
            drive(1'b1, 1'b1, d);
            tick();
            exp_d = q.pop_front();
            q.push_back(d);
            chk($sformatf("wrap%0d_dout", i), dout0, exp_d);
            chk($sformatf("wrap%0d_cnt", i), cnt1, 1);
        end

        // Reset mid-stream with wr/rd active
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'hEE);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        chk("mrst_count", cnt1, 0);
        chk("mrst_empty", empty1, 1);
        chk("mrst_dout", dout0, 0);
        tick();
        chk("mrst_still_empty", empty0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
